// File: rtl/fwd_hazard_unit_pkg.sv
//==============================================================================
// Module      : fwd_hazard_unit_pkg
// Description : Shared constants for the forwarding / load-use hazard unit.
//               Macro FWD_LOAD_STALL_EN enables load-use stall detection.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package fwd_hazard_unit_pkg;

  localparam int LEN_INST_REG = 5;
  localparam int FWD_SEL_RF   = 0;

`ifdef FWD_LOAD_STALL_EN
  localparam bit c_load_stall_en = 1'b1;
`else
  localparam bit c_load_stall_en = 1'b0;
`endif

endpackage

`default_nettype wire

// File: rtl/fwd_hazard_unit_match.sv
//==============================================================================
// Module      : fwd_match
// Description : Priority matcher of one EX source operand against all tracked
//               stages; youngest writer wins. Hazard honours FWD_LOAD_STALL_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fwd_match
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_W      = LEN_INST_REG,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = 2
)(
  input  logic [REG_W-1:0]            src,
  input  logic [FWD_STAGES-1:0]       stg_writer,
  input  logic [FWD_STAGES-1:0]       stg_load,
  input  logic [FWD_STAGES*REG_W-1:0] stg_rd,
  output logic [SEL_W-1:0]            sel,
  output logic                        hazard
);

  logic w_hit_load;

  // Walk oldest to youngest so the youngest matching writer overrides.
  // Register 0 can never match because writers exclude rd=0.
  always_comb begin
    sel        = SEL_W'(FWD_SEL_RF);
    w_hit_load = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (stg_writer[k-1] && (stg_rd[(k-1)*REG_W +: REG_W] == src)) begin
        sel        = SEL_W'(k);
        w_hit_load = stg_load[k-1] && (k <= LOAD_LAT);
      end
    end
  end

  assign hazard = c_load_stall_en & w_hit_load;

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
//==============================================================================
// Module      : fwd_hazard_unit
// Description : Forwarding select and load-use stall generation from a shadow
//               pipeline of destination tags. Macro FWD_LOAD_STALL_EN enables
//               load-use stalls and the stall counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter  int REG_W      = LEN_INST_REG,
  parameter  int NUM_SRC    = 2,
  parameter  int FWD_STAGES = 2,
  parameter  int LOAD_LAT   = 1,
  parameter  int CNT_W      = 16,
  localparam int SEL_W      = $clog2(FWD_STAGES + 1)
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  input  logic                     ex_regwrite,
  input  logic                     ex_is_load,
  input  logic [REG_W-1:0]         ex_rd,
  input  logic [NUM_SRC*REG_W-1:0] ex_src,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cnt
);

  // Stage k lives at bit / slice k-1.
  logic [FWD_STAGES-1:0]       r_valid;
  logic [FWD_STAGES-1:0]       r_regwrite;
  logic [FWD_STAGES-1:0]       r_is_load;
  logic [FWD_STAGES*REG_W-1:0] r_rd;

  logic [FWD_STAGES-1:0]       w_writer;
  logic [NUM_SRC-1:0]          w_hazard;
  logic [NUM_SRC*SEL_W-1:0]    w_sel;
  logic                        w_stall;

  always_comb begin
    w_writer = '0;
    for (int i = 0; i < FWD_STAGES; i++) begin
      w_writer[i] = r_valid[i] & r_regwrite[i] & (r_rd[i*REG_W +: REG_W] != '0);
    end
  end

  generate
    for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
      fwd_match #(
        .REG_W      (REG_W),
        .FWD_STAGES (FWD_STAGES),
        .LOAD_LAT   (LOAD_LAT),
        .SEL_W      (SEL_W)
      ) u_match (
        .src        (ex_src[j*REG_W +: REG_W]),
        .stg_writer (w_writer),
        .stg_load   (r_is_load),
        .stg_rd     (r_rd),
        .sel        (w_sel[j*SEL_W +: SEL_W]),
        .hazard     (w_hazard[j])
      );

      assign fwd_sel[j*SEL_W +: SEL_W] = (w_stall && w_hazard[j]) ?
                                         SEL_W'(FWD_SEL_RF) : w_sel[j*SEL_W +: SEL_W];
    end
  endgenerate

  assign w_stall = ex_valid & ~flush & (|w_hazard);
  assign stall   = w_stall;

  // Only the valid bits need reset/flush; payload fields are qualified by them.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_valid <= '0;
    end else begin
      for (int i = FWD_STAGES - 1; i >= 1; i--) begin
        r_valid[i] <= r_valid[i-1];
      end
      r_valid[0] <= ex_valid & ~w_stall;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = FWD_STAGES - 1; i >= 1; i--) begin
      r_regwrite[i]              <= r_regwrite[i-1];
      r_is_load[i]               <= r_is_load[i-1];
      r_rd[i*REG_W +: REG_W]     <= r_rd[(i-1)*REG_W +: REG_W];
    end
    r_regwrite[0]    <= ex_regwrite;
    r_is_load[0]     <= ex_is_load;
    r_rd[0 +: REG_W] <= ex_rd;
  end

`ifdef FWD_LOAD_STALL_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
//==============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Directed self-checking bench for fwd_hazard_unit (default and
//               LOAD_LAT=2 / FWD_STAGES=3 instances); honours FWD_LOAD_STALL_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fwd_hazard_unit;

`ifdef FWD_LOAD_STALL_EN
  localparam bit c_en = 1'b1;
`else
  localparam bit c_en = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       flush;

  logic       v1, rw1, ld1;
  logic [4:0] rd1, s1a, s1b;
  logic [3:0] sel1;
  logic       stall1;
  logic [15:0] cnt1;

  logic       v2, rw2, ld2;
  logic [4:0] rd2, s2a, s2b;
  logic [3:0] sel2;
  logic       stall2;
  logic [1:0] cnt2;

  int n_chk = 0;
  int n_err = 0;

  fwd_hazard_unit u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (v1),
    .ex_regwrite (rw1),
    .ex_is_load  (ld1),
    .ex_rd       (rd1),
    .ex_src      ({s1b, s1a}),
    .flush       (flush),
    .fwd_sel     (sel1),
    .stall       (stall1),
    .stall_cnt   (cnt1)
  );

  fwd_hazard_unit #(
    .FWD_STAGES (3),
    .LOAD_LAT   (2),
    .CNT_W      (2)
  ) u_dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (v2),
    .ex_regwrite (rw2),
    .ex_is_load  (ld2),
    .ex_rd       (rd2),
    .ex_src      ({s2b, s2a}),
    .flush       (1'b0),
    .fwd_sel     (sel2),
    .stall       (stall2),
    .stall_cnt   (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ex1(input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                     input logic [4:0] sa, input logic [4:0] sb);
    v1 = v; rw1 = rw; ld1 = ld; rd1 = rd; s1a = sa; s1b = sb;
  endtask

  task automatic ex2(input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                     input logic [4:0] sa);
    v2 = v; rw2 = rw; ld2 = ld; rd2 = rd; s2a = sa; s2b = 5'd0;
  endtask

  // Inputs change just after a rising edge; outputs are checked on the falling edge.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    ex1(0, 0, 0, 0, 0, 0);
    ex2(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    ex1(0, 0, 0, 0, 5'd10, 5'd13);
    mid();
    chk("rst_sel", 32'(sel1), 32'd0);
    chk("rst_stall", 32'(stall1), 32'd0);
    chk("rst_cnt", 32'(cnt1), 32'd0);
    chk("rst_sel2", 32'(sel2), 32'd0);

    // ALU producer rd=10 into stage 1
    nxt(); ex1(1, 1, 0, 5'd10, 0, 0);
    nxt(); ex1(1, 1, 0, 5'd10, 5'd10, 5'd13);
    mid();
    chk("alu_sel0", 32'(sel1[1:0]), 32'd1);
    chk("alu_sel1", 32'(sel1[3:2]), 32'd0);
    chk("alu_stall", 32'(stall1), 32'd0);

    // Both stages write r10: youngest wins
    nxt(); ex1(1, 0, 0, 5'd10, 5'd10, 0);
    mid();
    chk("prio_young", 32'(sel1[1:0]), 32'd1);

    // Stage 1 no longer writes: stage 2 supplies
    nxt(); ex1(1, 1, 0, 5'd0, 5'd10, 0);
    mid();
    chk("prio_old", 32'(sel1[1:0]), 32'd2);

    nxt(); ex1(1, 1, 0, 5'd0, 0, 0);
    nxt(); ex1(1, 1, 0, 5'd9, 5'd10, 5'd0);
    mid();
    chk("rd0_sel0", 32'(sel1[1:0]), 32'd0);
    chk("rd0_sel1", 32'(sel1[3:2]), 32'd0);

    // Load-use: load r8 then dependent instruction
    nxt(); ex1(1, 1, 1, 5'd8, 0, 0);
    nxt(); ex1(1, 1, 0, 5'd9, 5'd8, 5'd3);
    mid();
    chk("lu_stall", 32'(stall1), c_en ? 32'd1 : 32'd0);
    chk("lu_sel0", 32'(sel1[1:0]), c_en ? 32'd0 : 32'd1);
    nxt();
    mid();
    chk("lu_after_sel", 32'(sel1[1:0]), 32'd2);
    chk("lu_after_stall", 32'(stall1), 32'd0);
    chk("lu_cnt", 32'(cnt1), c_en ? 32'd1 : 32'd0);

    // Flush while a stall would be raised
    nxt(); ex1(1, 1, 1, 5'd5, 0, 0);
    nxt(); ex1(1, 1, 0, 5'd6, 5'd5, 5'd9); flush = 1'b1;
    mid();
    chk("fl_stall", 32'(stall1), 32'd0);
    chk("fl_sel0", 32'(sel1[1:0]), 32'd1);
    chk("fl_sel1", 32'(sel1[3:2]), 32'd2);
    nxt(); flush = 1'b0; ex1(0, 0, 0, 0, 5'd5, 5'd9);
    mid();
    chk("fl_after_sel", 32'(sel1), 32'd0);
    chk("fl_cnt", 32'(cnt1), c_en ? 32'd1 : 32'd0);

    // Reset in the middle of a stall
    nxt(); ex1(1, 1, 1, 5'd7, 0, 0);
    nxt(); ex1(1, 1, 0, 5'd4, 5'd7, 0);
    mid();
    chk("rs_stall", 32'(stall1), c_en ? 32'd1 : 32'd0);
    rst_n = 1'b0;
    nxt(); rst_n = 1'b1;
    mid();
    chk("rs_after_stall", 32'(stall1), 32'd0);
    chk("rs_after_sel", 32'(sel1), 32'd0);
    chk("rs_after_cnt", 32'(cnt1), 32'd0);

    // LOAD_LAT=2, FWD_STAGES=3 instance
    ex1(0, 0, 0, 0, 0, 0);
    nxt(); ex2(1, 1, 1, 5'd8, 0);
    nxt(); ex2(1, 1, 0, 5'd4, 5'd8);
    mid();
    chk("l2_stall_a", 32'(stall2), c_en ? 32'd1 : 32'd0);
    chk("l2_sel_a", 32'(sel2[1:0]), c_en ? 32'd0 : 32'd1);
    nxt();
    mid();
    chk("l2_stall_b", 32'(stall2), c_en ? 32'd1 : 32'd0);
    chk("l2_sel_b", 32'(sel2[1:0]), c_en ? 32'd0 : 32'd2);
    nxt();
    mid();
    chk("l2_stall_c", 32'(stall2), 32'd0);
    chk("l2_sel_c", 32'(sel2[1:0]), 32'd3);
    chk("l2_cnt", 32'(cnt2), c_en ? 32'd2 : 32'd0);

    // Saturation of a 2-bit counter
    nxt(); ex2(1, 1, 1, 5'd6, 0);
    nxt(); ex2(1, 1, 0, 5'd3, 5'd6);
    mid();
    chk("sat_stall_a", 32'(stall2), c_en ? 32'd1 : 32'd0);
    nxt();
    mid();
    chk("sat_stall_b", 32'(stall2), c_en ? 32'd1 : 32'd0);
    nxt(); ex2(0, 0, 0, 0, 5'd6);
    mid();
    chk("sat_cnt", 32'(cnt2), c_en ? 32'd3 : 32'd0);

    // Final reset clears the counter and outputs
    rst_n = 1'b0;
    nxt(); rst_n = 1'b1;
    mid();
    chk("fin_cnt2", 32'(cnt2), 32'd0);
    chk("fin_sel2", 32'(sel2), 32'd0);
    chk("fin_stall2", 32'(stall2), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
